usb_tx_packet_sequencer: RTL

- Downstream consumer of the USB endpoint data buffer on the transmit path.
- On a start request, emits a complete USB packet as a byte stream to the bit-level encoder (NRZI/bit-stuff serializer): SYNC, PID, optional payload drained from the buffer, CRC16, then an EOP request.
- Generates Get_TX_Packet_Data pops and computes the data CRC16 on the fly.

---
 rtl/usb_tx_packet_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/usb_tx_packet_sequencer.sv
// USB transmit packet sequencer: turns a start request into a byte stream
// (SYNC, PID, payload popped from the endpoint buffer, CRC16) followed by an
// EOP request to the bit-level serializer.
module usb_tx_packet_sequencer #(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [2:0] tx_pid_sel,
  input  logic [6:0] Buffer_Occupancy,
  input  logic [7:0] TX_Packet_Data,
  output logic       Get_TX_Packet_Data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       eop_req,
  input  logic       eop_done,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, FETCH, LOAD, DATA, CRC_LO, CRC_HI, EOP
  } state_t;

  state_t      state;
  logic [7:0]  pid;
  logic        is_data;
  logic [6:0]  len;
  logic [15:0] crc;
  logic [15:0] crc_nxt;
  logic        xfer;

  logic [7:0]  sel_pid;
  logic        sel_ok;
  logic        sel_data;
  logic [6:0]  clamp_len;

  // One byte of the reflected CRC16 (0xA001), data bits taken LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign xfer    = byte_valid && byte_ready;
  assign crc_nxt = crc16_byte(crc, byte_out);

  // The pop is decoded straight from FETCH so the buffer byte lands in the
  // LOAD cycle; gating on occupancy gives the underrun stall for free.
  assign Get_TX_Packet_Data = (state == FETCH) && (Buffer_Occupancy != 7'd0);

  // Decode the requested packet type into its PID byte and class.
  always_comb begin
    sel_pid  = 8'h00;
    sel_ok   = 1'b1;
    sel_data = 1'b0;
    case (tx_pid_sel)
      3'd1:    begin sel_pid = 8'hC3; sel_data = 1'b1; end
      3'd2:    begin sel_pid = 8'h4B; sel_data = 1'b1; end
      3'd3:    sel_pid = 8'hD2;
      3'd4:    sel_pid = 8'h5A;
      3'd5:    sel_pid = 8'h1E;
      default: sel_ok = 1'b0;
    endcase
    clamp_len = (Buffer_Occupancy > 7'(MAX_PAYLOAD)) ? 7'(MAX_PAYLOAD) : Buffer_Occupancy;
  end

  // Packet sequencing FSM with all stream/handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pid        <= 8'h00;
      is_data    <= 1'b0;
      len        <= 7'd0;
      crc        <= 16'hFFFF;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      eop_req    <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: if (tx_start) begin
          if (sel_ok) begin
            pid        <= sel_pid;
            is_data    <= sel_data;
            len        <= sel_data ? clamp_len : 7'd0;
            crc        <= 16'hFFFF;
            byte_out   <= 8'h80;
            byte_valid <= 1'b1;
            tx_busy    <= 1'b1;
            state      <= SYNC;
          end else begin
            tx_error <= 1'b1;
          end
        end
        SYNC: if (xfer) begin
          byte_out <= pid;
          state    <= PID;
        end
        PID: if (xfer) begin
          if (!is_data) begin
            byte_valid <= 1'b0;
            eop_req    <= 1'b1;
            state      <= EOP;
          end else if (len == 7'd0) begin
            byte_out <= ~crc[7:0];
            state    <= CRC_LO;
          end else begin
            byte_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: if (Buffer_Occupancy != 7'd0) state <= LOAD;
        LOAD: begin
          byte_out   <= TX_Packet_Data;
          byte_valid <= 1'b1;
          state      <= DATA;
        end
        DATA: if (xfer) begin
          crc <= crc_nxt;
          len <= len - 7'd1;
          if (len == 7'd1) begin
            byte_out <= ~crc_nxt[7:0];
            state    <= CRC_LO;
          end else begin
            byte_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        CRC_LO: if (xfer) begin
          byte_out <= ~crc[15:8];
          state    <= CRC_HI;
        end
        CRC_HI: if (xfer) begin
          byte_valid <= 1'b0;
          eop_req    <= 1'b1;
          state      <= EOP;
        end
        EOP: if (eop_done) begin
          eop_req <= 1'b0;
          tx_done <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
